// File: rtl/alu_share_arbiter.sv
// Round-robin sequencer sharing one combinational ALU between two requesters.
// Holds the winner's operands on the ALU for EXEC_CYCLES, then returns a registered response.
module alu_share_arbiter #(
    parameter int WIDTH       = 32,
    parameter int EXEC_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             r0_req,
    input  logic [3:0]       r0_alucon,
    input  logic [WIDTH-1:0] r0_a,
    input  logic [WIDTH-1:0] r0_b,
    output logic             r0_gnt,
    input  logic             r1_req,
    input  logic [3:0]       r1_alucon,
    input  logic [WIDTH-1:0] r1_a,
    input  logic [WIDTH-1:0] r1_b,
    output logic             r1_gnt,
    output logic [3:0]       alu_con,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_ovf,
    output logic             rsp_err,
    input  logic             rsp_ready,
    output logic             busy
);

    localparam int CW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q;
    logic [WIDTH-1:0] rsp_result_q;
    logic             rsp_ovf_q;
    logic             rsp_err_q;

    logic             win;
    logic             lat_en;
    logic             cap_en;
    logic [3:0]       sel_op;
    logic [WIDTH-1:0] sel_a, sel_b;
    logic             op_ok;
    logic             add_ovf, sub_ovf;

    function automatic logic is_legal(input logic [3:0] op);
        case (op)
            4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
            4'b0110, 4'b0111, 4'b1000, 4'b1001, 4'b1010: is_legal = 1'b1;
            default:                                     is_legal = 1'b0;
        endcase
    endfunction

    // Sole requester wins; on a tie the port not served last time wins.
    assign win    = (r0_req && r1_req) ? ~last_q : r1_req;
    assign sel_op = win ? r1_alucon : r0_alucon;
    assign sel_a  = win ? r1_a : r0_a;
    assign sel_b  = win ? r1_b : r0_b;

    assign op_ok   = is_legal(op_q);
    assign add_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (alu_result[WIDTH-1] != a_q[WIDTH-1]);
    assign sub_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (alu_result[WIDTH-1] != a_q[WIDTH-1]);

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        lat_en      = 1'b0;
        cap_en      = 1'b0;
        rsp_valid_d = rsp_valid_q;
        case (state_q)
            IDLE: begin
                if (r0_req || r1_req) begin
                    lat_en  = 1'b1;
                    last_d  = win;
                    gnt0_d  = ~win;
                    gnt1_d  = win;
                    cnt_d   = CW'(EXEC_CYCLES - 1);
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    cap_en      = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            cnt_q       <= '0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_ovf_q    <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            if (lat_en) begin
                op_q <= sel_op;
                a_q  <= sel_a;
                b_q  <= sel_b;
            end
            // last_q already holds the port being served by the time EXEC ends.
            if (cap_en) begin
                rsp_id_q     <= last_q;
                rsp_result_q <= op_ok ? alu_result : '0;
                rsp_ovf_q    <= op_ok && (((op_q == 4'b0010) && add_ovf) ||
                                          ((op_q == 4'b0110) && sub_ovf));
                rsp_err_q    <= ~op_ok;
            end
        end
    end

    // ALU inputs are parked at zero outside EXEC; illegal opcodes are presented as 0000.
    always_comb begin
        alu_con = '0;
        alu_a   = '0;
        alu_b   = '0;
        if (state_q == EXEC) begin
            alu_con = op_ok ? op_q : 4'b0000;
            alu_a   = a_q;
            alu_b   = b_q;
        end
    end

    assign r0_gnt     = gnt0_q;
    assign r1_gnt     = gnt1_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_ovf    = rsp_ovf_q;
    assign rsp_err    = rsp_err_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: instance 0 uses EXEC_CYCLES=1, instance 1 uses EXEC_CYCLES=3.
// A transaction-level model is checked every cycle; directed tests pin literal values.
module tb_alu_share_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        req0 [2];
    logic        req1 [2];
    logic [3:0]  op0  [2];
    logic [3:0]  op1  [2];
    logic [31:0] a0   [2];
    logic [31:0] b0   [2];
    logic [31:0] a1   [2];
    logic [31:0] b1   [2];
    logic        ready[2];

    logic        gnt0 [2];
    logic        gnt1 [2];
    logic [3:0]  acon [2];
    logic [31:0] aa   [2];
    logic [31:0] ab   [2];
    logic [31:0] ares [2];
    logic        rv   [2];
    logic        rid  [2];
    logic [31:0] rres [2];
    logic        rovf [2];
    logic        rerr [2];
    logic        busy [2];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'b0000: alu_fn = a & b;
            4'b0001: alu_fn = a | b;
            4'b0010: alu_fn = a + b;
            4'b0011: alu_fn = a * b;
            4'b0100: alu_fn = a ^ b;
            4'b0110: alu_fn = a - b;
            4'b0111: alu_fn = {31'd0, $signed(a) < $signed(b)};
            4'b1000: alu_fn = a << b[4:0];
            4'b1001: alu_fn = a - b;
            4'b1010: alu_fn = a >> b[4:0];
            default: alu_fn = 32'hDEAD_BEEF;
        endcase
    endfunction

    assign ares[0] = alu_fn(acon[0], aa[0], ab[0]);
    assign ares[1] = alu_fn(acon[1], aa[1], ab[1]);

    alu_share_arbiter #(.WIDTH(32), .EXEC_CYCLES(1)) dut (
        .clk(clk), .reset(rst),
        .r0_req(req0[0]), .r0_alucon(op0[0]), .r0_a(a0[0]), .r0_b(b0[0]), .r0_gnt(gnt0[0]),
        .r1_req(req1[0]), .r1_alucon(op1[0]), .r1_a(a1[0]), .r1_b(b1[0]), .r1_gnt(gnt1[0]),
        .alu_con(acon[0]), .alu_a(aa[0]), .alu_b(ab[0]), .alu_result(ares[0]),
        .rsp_valid(rv[0]), .rsp_id(rid[0]), .rsp_result(rres[0]), .rsp_ovf(rovf[0]),
        .rsp_err(rerr[0]), .rsp_ready(ready[0]), .busy(busy[0])
    );

    alu_share_arbiter #(.WIDTH(32), .EXEC_CYCLES(3)) dut3 (
        .clk(clk), .reset(rst),
        .r0_req(req0[1]), .r0_alucon(op0[1]), .r0_a(a0[1]), .r0_b(b0[1]), .r0_gnt(gnt0[1]),
        .r1_req(req1[1]), .r1_alucon(op1[1]), .r1_a(a1[1]), .r1_b(b1[1]), .r1_gnt(gnt1[1]),
        .alu_con(acon[1]), .alu_a(aa[1]), .alu_b(ab[1]), .alu_result(ares[1]),
        .rsp_valid(rv[1]), .rsp_id(rid[1]), .rsp_result(rres[1]), .rsp_ovf(rovf[1]),
        .rsp_err(rerr[1]), .rsp_ready(ready[1]), .busy(busy[1])
    );

    task automatic check(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    int          m_exec [2];
    bit          m_busy [2];
    int          m_left [2];
    bit          m_last [2];
    bit          m_id   [2];
    logic [3:0]  m_op   [2];
    logic [31:0] m_a    [2];
    logic [31:0] m_b    [2];
    bit          m_gnt0 [2];
    bit          m_gnt1 [2];
    bit          m_valid[2];
    logic [31:0] m_res  [2];
    bit          m_ovf  [2];
    bit          m_err  [2];

    function automatic bit legal_ref(input logic [3:0] op);
        int unsigned ok_list[10] = '{0, 1, 2, 3, 4, 6, 7, 8, 9, 10};
        foreach (ok_list[i]) if (ok_list[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    // Signed overflow: the true sum/difference does not fit in 32 signed bits.
    function automatic bit ovf_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint r;
        if (op == 4'b0010) r = sa + sb;
        else if (op == 4'b0110) r = sa - sb;
        else return 1'b0;
        return r != longint'($signed(r[31:0]));
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_busy[k] = 0; m_left[k] = 0; m_last[k] = 1; m_id[k] = 0;
            m_op[k] = '0; m_a[k] = '0; m_b[k] = '0;
            m_gnt0[k] = 0; m_gnt1[k] = 0; m_valid[k] = 0;
            m_res[k] = '0; m_ovf[k] = 0; m_err[k] = 0;
        end
    endtask

    task automatic model_step(input int k);
        bit w;
        m_gnt0[k] = 0;
        m_gnt1[k] = 0;
        if (!m_busy[k]) begin
            if (req0[k] || req1[k]) begin
                w = (req0[k] && req1[k]) ? !m_last[k] : req1[k];
                m_last[k] = w;
                m_id[k]   = w;
                m_op[k]   = w ? op1[k] : op0[k];
                m_a[k]    = w ? a1[k] : a0[k];
                m_b[k]    = w ? b1[k] : b0[k];
                m_gnt0[k] = !w;
                m_gnt1[k] = w;
                m_busy[k] = 1;
                m_left[k] = m_exec[k];
            end
        end else if (m_left[k] > 0) begin
            m_left[k]--;
            if (m_left[k] == 0) begin
                m_valid[k] = 1;
                m_err[k]   = !legal_ref(m_op[k]);
                m_res[k]   = m_err[k] ? 32'd0 : alu_fn(m_op[k], m_a[k], m_b[k]);
                m_ovf[k]   = !m_err[k] && ovf_ref(m_op[k], m_a[k], m_b[k]);
            end
        end else if (ready[k]) begin
            m_valid[k] = 0;
            m_busy[k]  = 0;
        end
    endtask

    initial begin
        m_exec[0] = 1;
        m_exec[1] = 3;
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else for (int k = 0; k < 2; k++) model_step(k);
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                bit in_exec;
                in_exec = m_busy[k] && (m_left[k] > 0);
                check($sformatf("m%0d_gnt0", k), gnt0[k], m_gnt0[k]);
                check($sformatf("m%0d_gnt1", k), gnt1[k], m_gnt1[k]);
                check($sformatf("m%0d_busy", k), busy[k], m_busy[k]);
                check($sformatf("m%0d_valid", k), rv[k], m_valid[k]);
                check($sformatf("m%0d_alu_con", k), acon[k],
                      (in_exec && legal_ref(m_op[k])) ? m_op[k] : 4'd0);
                check($sformatf("m%0d_alu_a", k), aa[k], in_exec ? m_a[k] : 32'd0);
                check($sformatf("m%0d_alu_b", k), ab[k], in_exec ? m_b[k] : 32'd0);
                if (m_valid[k]) begin
                    check($sformatf("m%0d_rsp_id", k), rid[k], m_id[k]);
                    check($sformatf("m%0d_rsp_result", k), rres[k], m_res[k]);
                    check($sformatf("m%0d_rsp_ovf", k), rovf[k], m_ovf[k]);
                    check($sformatf("m%0d_rsp_err", k), rerr[k], m_err[k]);
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int k, input int p, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        if (p == 0) begin op0[k] = op; a0[k] = a; b0[k] = b; end
        else        begin op1[k] = op; a1[k] = a; b1[k] = b; end
    endtask

    task automatic wait_gnt(input int k, output int port);
        port = -1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (gnt0[k] || gnt1[k]) begin
                port = gnt1[k] ? 1 : 0;
                break;
            end
        end
        if (port < 0) check("gnt_timeout", 1, 0);
    endtask

    task automatic wait_rsp(input int k);
        bit seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rv[k]) begin
                seen = 1;
                break;
            end
        end
        if (!seen) check("rsp_timeout", 1, 0);
    endtask

    // Issue one op on port 0 of instance k and return the captured response.
    task automatic do_op0(input int k, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic ovf, output logic err);
        int p;
        set_port(k, 0, op, a, b);
        req0[k] = 1;
        wait_gnt(k, p);
        req0[k] = 0;
        check("op_port", p, 0);
        wait_rsp(k);
        res = rres[k];
        ovf = rovf[k];
        err = rerr[k];
        tick();
    endtask

    initial begin
        logic [31:0] res, held_res;
        logic        ovf, err, held_id;
        int          p;
        int          exp_order[4] = '{0, 1, 0, 1};

        rst = 1;
        for (int k = 0; k < 2; k++) begin
            req0[k] = 0; req1[k] = 0; ready[k] = 1;
            set_port(k, 0, 4'd0, 32'd0, 32'd0);
            set_port(k, 1, 4'd0, 32'd0, 32'd0);
        end
        tick();
        tick();
        check("reset_busy", busy[0], 0);
        check("reset_valid", rv[0], 0);
        check("reset_alu_con", acon[0], 0);
        rst = 0;
        tick();

        // Port 0 alone: ADD 5+7, fixed latency.
        set_port(0, 0, 4'b0010, 32'd5, 32'd7);
        req0[0] = 1;
        tick();
        check("t1_gnt_c1", gnt0[0], 1);
        check("t1_alu_con_c1", acon[0], 4'b0010);
        req0[0] = 0;
        tick();
        check("t1_valid_c2", rv[0], 1);
        check("t1_id", rid[0], 0);
        check("t1_result", rres[0], 32'd12);
        check("t1_ovf", rovf[0], 0);
        check("t1_err", rerr[0], 0);
        tick();
        check("t1_busy_c3", busy[0], 0);

        // Overflow boundaries.
        do_op0(0, 4'b0010, 32'h7FFF_FFFF, 32'h1, res, ovf, err);
        check("add_ovf_res", res, 32'h8000_0000);
        check("add_ovf", ovf, 1);
        do_op0(0, 4'b0110, 32'h8000_0000, 32'h1, res, ovf, err);
        check("sub_ovf_res", res, 32'h7FFF_FFFF);
        check("sub_ovf", ovf, 1);
        do_op0(0, 4'b1001, 32'h8000_0000, 32'h1, res, ovf, err);
        check("subu_ovf", ovf, 0);
        do_op0(0, 4'b0011, 32'h7FFF_FFFF, 32'h2, res, ovf, err);
        check("mul_res", res, 32'hFFFF_FFFE);
        check("mul_ovf", ovf, 0);

        // Reset pulse mid-EXEC drops the in-flight op.
        set_port(0, 1, 4'b0010, 32'd1, 32'd1);
        req1[0] = 1;
        tick();
        check("rst_gnt1", gnt1[0], 1);
        req1[0] = 0;
        #1 rst = 1;
        #1;
        check("rst_busy", busy[0], 0);
        check("rst_gnt1_low", gnt1[0], 0);
        check("rst_alu_con", acon[0], 0);
        check("rst_alu_a", aa[0], 0);
        #1 rst = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_no_rsp", rv[0], 0);
        end

        // Both ports request together: grants alternate starting with port 0.
        set_port(0, 0, 4'b0000, 32'hFFFF_0000, 32'h0F0F_0F0F);
        set_port(0, 1, 4'b0110, 32'd10, 32'd3);
        req0[0] = 1;
        req1[0] = 1;
        for (int i = 0; i < 4; i++) begin
            wait_gnt(0, p);
            check("both_order", p, exp_order[i]);
            if (p == 0) req0[0] = 0; else req1[0] = 0;
            wait_rsp(0);
            check("both_id", rid[0], exp_order[i]);
            check("both_res", rres[0], (exp_order[i] == 0) ? 32'h0F0F_0000 : 32'd7);
            if (i < 3) begin
                if (p == 0) req0[0] = 1; else req1[0] = 1;
            end else begin
                req0[0] = 0;
                req1[0] = 0;
            end
        end
        tick();

        // Backpressure: response held, pending port 1 request waits.
        ready[0] = 0;
        set_port(0, 0, 4'b0001, 32'h0000_00F0, 32'h0000_0F00);
        set_port(0, 1, 4'b0010, 32'd2, 32'd3);
        req0[0] = 1;
        wait_gnt(0, p);
        req0[0] = 0;
        req1[0] = 1;
        wait_rsp(0);
        held_res = rres[0];
        held_id  = rid[0];
        check("bp_res", held_res, 32'h0000_0FF0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid_held", rv[0], 1);
            check("bp_res_held", rres[0], held_res);
            check("bp_id_held", rid[0], held_id);
            check("bp_no_gnt", gnt1[0], 0);
        end
        ready[0] = 1;
        tick();
        check("bp_idle_valid", rv[0], 0);
        check("bp_idle_no_gnt", gnt1[0], 0);
        tick();
        check("bp_gnt1", gnt1[0], 1);
        req1[0] = 0;
        wait_rsp(0);
        check("bp_p1_res", rres[0], 32'd5);
        check("bp_p1_id", rid[0], 1);
        tick();

        // EXEC_CYCLES=3 instance: illegal opcode, then a legal op.
        set_port(1, 0, 4'b0101, 32'd3, 32'd4);
        req0[1] = 1;
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (c == 1) begin
                check("ill_gnt", gnt0[1], 1);
                req0[1] = 0;
            end
            check("ill_alu_con", acon[1], 0);
            check("ill_no_valid", rv[1], 0);
        end
        tick();
        check("ill_valid_c4", rv[1], 1);
        check("ill_err", rerr[1], 1);
        check("ill_res", rres[1], 0);
        tick();
        set_port(1, 0, 4'b0010, 32'd9, 32'd8);
        req0[1] = 1;
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (c == 1) req0[1] = 0;
            check("e3_alu_con", acon[1], 4'b0010);
        end
        tick();
        check("e3_valid_c4", rv[1], 1);
        check("e3_res", rres[1], 32'd17);
        check("e3_err", rerr[1], 0);
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
